// File: rtl/mem_access.sv
// mem_access: data-memory access stage between execute and writeback.
// Each accepted op is classified once, issued as at most one dmem request,
// and its result is presented to writeback as a single-cycle out_valid pulse.
module mem_access #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic [WIDTH-1:0] dmem_addr,
  output logic             dmem_we,
  output logic [3:0]       dmem_be,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_rsp_valid,
  input  logic [WIDTH-1:0] dmem_rsp_rdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rd,
  output logic             out_reg_write,
  output logic             fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Latched operation context (captured on accept)
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] wdata_reg;
  logic [3:0]       be_reg;
  logic             we_reg;
  logic [2:0]       funct3_reg;
  logic [4:0]       rd_reg;
  logic             reg_write_reg;
  logic             fault_reg;
  logic [WIDTH-1:0] data_reg;

  // Classification of the incoming op
  logic             accept;
  logic             is_mem;
  logic             is_half;
  logic             is_word;
  logic             bad_load;
  logic             bad_store;
  logic             misaligned;
  logic             acc_fault;
  logic [3:0]       acc_be;
  logic [WIDTH-1:0] acc_wdata;

  // Load data alignment
  logic [WIDTH-1:0] rsp_shifted;
  logic [WIDTH-1:0] load_data;

  assign accept  = in_valid && (state_reg == IDLE);
  assign is_mem  = mem_read || mem_write;
  assign is_half = (funct3[1:0] == 2'b01);
  assign is_word = (funct3[1:0] == 2'b10);

  // Decode faults, lane mask and lane-replicated store data for the incoming op
  always_comb begin
    bad_load   = mem_read && ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    bad_store  = mem_write && (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
    misaligned = is_mem && ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
    acc_fault  = (mem_read && mem_write) || bad_load || bad_store || misaligned;

    acc_be    = 4'b1111;
    acc_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        acc_be    = 4'b0001 << addr[1:0];
        acc_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        acc_be    = addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{store_data[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = store_data;
      end
    endcase
    // Loads never drive write data onto the bus
    if (!mem_write) acc_wdata = '0;
  end

  // Align the response to lane 0 and sign/zero-extend by access size
  always_comb begin
    rsp_shifted = dmem_rsp_rdata >> {addr_reg[1:0], 3'b000};
    case (funct3_reg)
      3'b000:  load_data = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_data = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  load_data = {24'd0, rsp_shifted[7:0]};
      3'b101:  load_data = {16'd0, rsp_shifted[15:0]};
      default: load_data = rsp_shifted;
    endcase
  end

  // State register; reset abandons any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = (acc_fault || !is_mem) ? DONE : REQ;
      REQ:  if (dmem_req_ready) state_next = we_reg ? DONE : RESP;
      RESP: if (dmem_rsp_valid) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture op context on accept; capture load data only while in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      be_reg        <= '0;
      we_reg        <= 1'b0;
      funct3_reg    <= '0;
      rd_reg        <= '0;
      reg_write_reg <= 1'b0;
      fault_reg     <= 1'b0;
      data_reg      <= '0;
    end else if (accept) begin
      addr_reg      <= addr;
      wdata_reg     <= acc_wdata;
      be_reg        <= acc_be;
      we_reg        <= mem_write;
      funct3_reg    <= funct3;
      rd_reg        <= rd;
      reg_write_reg <= reg_write;
      fault_reg     <= acc_fault;
      data_reg      <= addr;
    end else if (state_reg == RESP && dmem_rsp_valid) begin
      data_reg <= load_data;
    end
  end

  // Outputs decoded from registered state and context; zero outside their phase
  always_comb begin
    in_ready       = (state_reg == IDLE);
    dmem_req_valid = (state_reg == REQ);
    dmem_addr      = '0;
    dmem_we        = 1'b0;
    dmem_be        = '0;
    dmem_wdata     = '0;
    out_valid      = (state_reg == DONE);
    out_data       = '0;
    out_rd         = '0;
    out_reg_write  = 1'b0;
    fault          = 1'b0;
    if (state_reg == REQ) begin
      dmem_addr  = {addr_reg[WIDTH-1:2], 2'b00};
      dmem_we    = we_reg;
      dmem_be    = be_reg;
      dmem_wdata = wdata_reg;
    end
    if (state_reg == DONE) begin
      out_data      = data_reg;
      out_rd        = rd_reg;
      out_reg_write = reg_write_reg && !fault_reg;
      fault         = fault_reg;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access against a
// byte-level reference model of the access rules.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b0;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rsp_rdata = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .store_data(store_data),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .rd(rd), .reg_write(reg_write),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .fault(fault)
  );

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit model_fault(input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a);
    if (r && w) return 1;
    if (r && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1;
    if (w && f3 > 3'd2) return 1;
    if ((r || w) && (a % op_size(f3)) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int off;
    off = a % 4;
    be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + op_size(f3));
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] wd;
    int sz;
    sz = op_size(f3);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % sz) +: 8];
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
    longint v;
    int off, sz;
    off = a % 4;
    sz = op_size(f3);
    v = 0;
    for (int j = 0; j < sz; j++) v += longint'(rdata[8*(off+j) +: 8]) << (8*j);
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8*sz-1))) v -= (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  // ---------------- op driver / memory responder ----------------
  // Issues one op from IDLE, plays the memory side, and reports what it saw.
  task automatic run_op(
    input bit r, input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
    input logic [4:0] rdv, input bit rw, input int req_wait, input int rsp_wait, input logic [31:0] rdata,
    output int lat, output logic [31:0] o_data, output bit o_fault, output bit o_rw, output logic [4:0] o_rd,
    output int req_cycles, output bit stable, output logic [31:0] q_addr, output logic [31:0] q_wdata,
    output logic [3:0] q_be, output bit q_we, output int busy_bad);
    int cyc, after;
    bit done, hs;
    lat = -1; o_data = '0; o_fault = 0; o_rw = 0; o_rd = '0;
    req_cycles = 0; stable = 1; q_addr = '0; q_wdata = '0; q_be = '0; q_we = 0; busy_bad = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
    in_valid = 1; mem_read = r; mem_write = w; funct3 = f3; addr = a;
    store_data = sd; rd = rdv; reg_write = rw;
    @(posedge clk); #1;
    in_valid = 0; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    rd = 5'($urandom); mem_read = 0; mem_write = 0; reg_write = 0;
    cyc = 1; done = 0; hs = 0; after = 0;
    while (!done && cyc < 100) begin
      dmem_req_ready = 0;
      dmem_rsp_valid = 0;
      if (in_ready !== 1'b0) busy_bad++;
      if (out_valid === 1'b1) begin
        o_data = out_data; o_fault = fault; o_rw = out_reg_write; o_rd = out_rd;
        lat = cyc; done = 1;
      end else if (dmem_req_valid === 1'b1) begin
        if (req_cycles == 0) begin
          q_addr = dmem_addr; q_wdata = dmem_wdata; q_be = dmem_be; q_we = dmem_we;
        end else if (q_addr !== dmem_addr || q_wdata !== dmem_wdata || q_be !== dmem_be || q_we !== dmem_we) begin
          stable = 0;
        end
        if (req_cycles == req_wait) begin
          dmem_req_ready = 1;
          hs = 1;
        end
        req_cycles++;
      end else if (hs) begin
        if (after == rsp_wait) begin
          dmem_rsp_valid = 1;
          dmem_rsp_rdata = rdata;
        end else begin
          dmem_rsp_rdata = $urandom;
        end
        after++;
      end
      if (!done) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    dmem_req_ready = 0;
    dmem_rsp_valid = 0;
    @(posedge clk); #1;
  endtask

  // Shared result holders for the scenario tasks
  int          lat, req_cycles, busy_bad;
  logic [31:0] o_data, q_addr, q_wdata;
  logic [4:0]  o_rd;
  logic [3:0]  q_be;
  bit          o_fault, o_rw, stable, q_we;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata, out_valid, out_data, out_rd, out_reg_write, fault} !== '0) begin
      errors++; $display("FAIL reset_outputs: got req_valid=%b dmem_addr=%h out_valid=%b out_data=%h expected all zero",
                         dmem_req_valid, dmem_addr, out_valid, out_data);
    end
    rst_n = 1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_nonmem();
    run_op(0, 0, 3'b010, 32'h1234_5678, 32'hFFFF_0000, 5'd5, 1, 0, 0, '0,
           lat, o_data, o_fault, o_rw, o_rd, req_cycles, stable, q_addr, q_wdata, q_be, q_we, busy_bad);
    $display("nonmem: lat=%0d data=%h rd=%0d", lat, o_data, o_rd);
    checks++; if (lat != 1) begin errors++; $display("FAIL nonmem_latency: got %0d expected 1", lat); end
    checks++; if (o_data !== 32'h1234_5678) begin errors++; $display("FAIL nonmem_data: got %h expected 12345678", o_data); end
    checks++; if (o_rd !== 5'd5 || o_rw !== 1'b1 || o_fault !== 1'b0) begin
      errors++; $display("FAIL nonmem_tag: got rd=%0d rw=%b fault=%b expected rd=5 rw=1 fault=0", o_rd, o_rw, o_fault);
    end
    checks++; if (req_cycles != 0) begin errors++; $display("FAIL nonmem_no_req: got %0d req cycles expected 0", req_cycles); end
  endtask

  task automatic test_store_stall();
    run_op(0, 1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd7, 0, 3, 0, '0,
           lat, o_data, o_fault, o_rw, o_rd, req_cycles, stable, q_addr, q_wdata, q_be, q_we, busy_bad);
    $display("sb: lat=%0d be=%b wdata=%h req_cycles=%0d", lat, q_be, q_wdata, req_cycles);
    checks++; if (q_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", q_be); end
    checks++; if (q_wdata !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_wdata: got %h expected dddddddd", q_wdata); end
    checks++; if (q_addr !== 32'h0000_0100 || q_we !== 1'b1) begin
      errors++; $display("FAIL sb_addr_we: got addr=%h we=%b expected addr=00000100 we=1", q_addr, q_we);
    end
    checks++; if (req_cycles != 4 || !stable) begin
      errors++; $display("FAIL sb_req_hold: got cycles=%0d stable=%b expected cycles=4 stable=1", req_cycles, stable);
    end
    checks++; if (lat != 5) begin errors++; $display("FAIL sb_latency: got %0d expected 5", lat); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL sb_in_ready: got %0d busy cycles with in_ready high expected 0", busy_bad); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] as  [3] = '{32'h102, 32'h102, 32'h2};
    logic [31:0] rds [3] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000};
    logic [31:0] exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
    for (int i = 0; i < 3; i++) begin
      run_op(1, 0, f3s[i], as[i], 32'h0, 5'd9, 1, 0, 0, rds[i],
             lat, o_data, o_fault, o_rw, o_rd, req_cycles, stable, q_addr, q_wdata, q_be, q_we, busy_bad);
      $display("load f3=%b addr=%h: lat=%0d data=%h", f3s[i], as[i], lat, o_data);
      checks++; if (o_data !== exp[i]) begin errors++; $display("FAIL load_data_%0d: got %h expected %h", i, o_data, exp[i]); end
      checks++; if (lat != 3) begin errors++; $display("FAIL load_latency_%0d: got %0d expected 3", i, lat); end
      checks++; if (q_wdata !== 32'h0 || q_we !== 1'b0) begin
        errors++; $display("FAIL load_req_%0d: got wdata=%h we=%b expected wdata=0 we=0", i, q_wdata, q_we);
      end
    end
  endtask

  task automatic test_fault();
    for (int i = 0; i < 2; i++) begin
      run_op(1, i == 1, 3'b010, (i == 0) ? 32'h6 : 32'h8, 32'h0, 5'd3, 1, 0, 0, '0,
             lat, o_data, o_fault, o_rw, o_rd, req_cycles, stable, q_addr, q_wdata, q_be, q_we, busy_bad);
      $display("fault case %0d: lat=%0d fault=%b rw=%b", i, lat, o_fault, o_rw);
      checks++; if (lat != 1 || o_fault !== 1'b1 || o_rw !== 1'b0) begin
        errors++; $display("FAIL fault_%0d: got lat=%0d fault=%b rw=%b expected lat=1 fault=1 rw=0", i, lat, o_fault, o_rw);
      end
      checks++; if (req_cycles != 0) begin errors++; $display("FAIL fault_no_req_%0d: got %0d expected 0", i, req_cycles); end
    end
  endtask

  task automatic test_spurious();
    int seen;
    seen = 0;
    dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hDEAD_BEEF;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    dmem_rsp_valid = 0;
    checks++; if (seen != 0) begin errors++; $display("FAIL spurious_idle: got %0d out_valid cycles expected 0", seen); end
    run_op(1, 0, 3'b010, 32'h40, 32'h0, 5'd11, 1, 0, 5, 32'h1357_2468,
           lat, o_data, o_fault, o_rw, o_rd, req_cycles, stable, q_addr, q_wdata, q_be, q_we, busy_bad);
    $display("lw delayed: lat=%0d data=%h", lat, o_data);
    checks++; if (o_data !== 32'h1357_2468) begin errors++; $display("FAIL spurious_data: got %h expected 13572468", o_data); end
    checks++; if (lat != 8) begin errors++; $display("FAIL spurious_latency: got %0d expected 8", lat); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL spurious_in_ready: got %0d expected 0", busy_bad); end
  endtask

  task automatic test_reset_in_resp();
    int seen;
    in_valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h80; rd = 5'd4; reg_write = 1;
    @(posedge clk); #1;
    in_valid = 0; mem_read = 0;
    dmem_req_ready = 1;
    @(posedge clk); #1;
    dmem_req_ready = 0;
    checks++; if (in_ready !== 1'b0 || dmem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_resp_setup: got in_ready=%b req_valid=%b expected 0 0", in_ready, dmem_req_valid);
    end
    #2 rst_n = 0;
    #1;
    checks++; if (in_ready !== 1'b1 || {dmem_req_valid, out_valid, out_data, out_rd, out_reg_write, fault, dmem_be} !== '0) begin
      errors++; $display("FAIL rst_resp_outputs: got in_ready=%b out_valid=%b out_data=%h expected 1 0 0", in_ready, out_valid, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hCAFE_F00D;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
      dmem_rsp_valid = 0;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_resp_late_rsp: got %0d out_valid cycles expected 0", seen); end
    run_op(0, 0, 3'b000, 32'h0BAD_CAFE, 32'h0, 5'd12, 1, 0, 0, '0,
           lat, o_data, o_fault, o_rw, o_rd, req_cycles, stable, q_addr, q_wdata, q_be, q_we, busy_bad);
    $display("after reset: lat=%0d data=%h", lat, o_data);
    checks++; if (lat != 1 || o_data !== 32'h0BAD_CAFE || o_rd !== 5'd12) begin
      errors++; $display("FAIL rst_resp_next_op: got lat=%0d data=%h rd=%0d expected 1 0badcafe 12", lat, o_data, o_rd);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    in_valid = 1; mem_read = 0; mem_write = 0; addr = 32'h55; rd = 5'd1; reg_write = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) pulses++;
    end
    in_valid = 0;
    @(posedge clk); #1;
    $display("back_to_back: %0d results in 20 cycles", pulses);
    checks++; if (pulses != 10) begin errors++; $display("FAIL b2b_throughput: got %0d expected 10", pulses); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit r, w, flt;
      logic [2:0]  f3;
      logic [31:0] a, sd, rdat, exp_data;
      logic [4:0]  rdv;
      bit rw;
      int rq, rs, exp_lat, kind;
      kind = $urandom_range(0, 3);
      r = (kind == 1) || (kind == 3);
      w = (kind == 2) || (kind == 3);
      if (kind == 3 && $urandom_range(0, 3) != 0) w = 0;
      f3 = 3'($urandom);
      a = $urandom; sd = $urandom; rdat = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      rdv = 5'($urandom); rw = 1'($urandom);
      rq = $urandom_range(0, 3); rs = $urandom_range(0, 3);
      flt = model_fault(r, w, f3, a);
      if (flt || !(r || w)) exp_lat = 1;
      else if (w)           exp_lat = rq + 2;
      else                  exp_lat = rq + 3 + rs;
      exp_data = (r && !w) ? model_load(f3, a, rdat) : a;
      run_op(r, w, f3, a, sd, rdv, rw, rq, rs, rdat,
             lat, o_data, o_fault, o_rw, o_rd, req_cycles, stable, q_addr, q_wdata, q_be, q_we, busy_bad);
      $display("rand %0d: r=%b w=%b f3=%b addr=%h lat=%0d data=%h fault=%b", n, r, w, f3, a, lat, o_data, o_fault);
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL rand_latency_%0d: got %0d expected %0d", n, lat, exp_lat); end
      checks++; if (o_fault !== flt || o_rw !== (rw && !flt) || o_rd !== rdv) begin
        errors++; $display("FAIL rand_tag_%0d: got fault=%b rw=%b rd=%0d expected fault=%b rw=%b rd=%0d",
                           n, o_fault, o_rw, o_rd, flt, rw && !flt, rdv);
      end
      if (!flt) begin
        checks++; if (o_data !== exp_data) begin errors++; $display("FAIL rand_data_%0d: got %h expected %h", n, o_data, exp_data); end
      end
      if (!flt && (r || w)) begin
        checks++;
        if (q_be !== model_be(f3, a) || q_we !== w || q_addr !== {a[31:2], 2'b00} ||
            q_wdata !== (w ? model_wdata(f3, sd) : 32'h0) || !stable) begin
          errors++; $display("FAIL rand_req_%0d: got be=%b we=%b addr=%h wdata=%h stable=%b expected be=%b we=%b addr=%h wdata=%h",
                             n, q_be, q_we, q_addr, q_wdata, stable, model_be(f3, a), w, {a[31:2], 2'b00},
                             w ? model_wdata(f3, sd) : 32'h0);
        end
      end else begin
        checks++; if (req_cycles != 0) begin errors++; $display("FAIL rand_no_req_%0d: got %0d expected 0", n, req_cycles); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store_stall();
    test_loads();
    test_fault();
    test_spurious();
    test_reset_in_resp();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage that sits directly downstream of the execute stage and consumes its results: ALU result as effective address, `rs2` value as store data, plus the memory control bits. Converts each accepted operation into a single request on the data-memory port using a valid/ready handshake. It waits for the load response, aligns and sign/zero-extends load data, and hands the result to writeback. It back-pressures the pipeline with `in_ready` while a transaction is outstanding.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported (4 byte lanes)
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `in_valid` input 1: execute result valid
- `in_ready` output 1: stage can accept; `(state == IDLE)`
- `addr` input WIDTH: effective address (execute ALU result)
- `store_data` input WIDTH: store data (execute `rs2` pass-through)
- `mem_read` input 1: load
- `mem_write` input 1: store
- `funct3` input 3: size/sign; 000 B, 001 H, 010 W, 100 BU, 101 HU
- `rd` input 5, `reg_write` input 1: writeback tag, carried through
- `dmem_req_valid` output 1, `dmem_req_ready` input 1: request handshake
- `dmem_addr` output WIDTH: word-aligned address, `{addr[31:2],2'b00}`
- `dmem_we` output 1: 1 = write
- `dmem_be` output 4: byte enables
- `dmem_wdata` output WIDTH: lane-replicated store data
- `dmem_rsp_valid` input 1, `dmem_rsp_rdata` input WIDTH: load response, no ready
- `out_valid` output 1: one-cycle pulse, result to writeback (writeback always accepts)
- `out_data` output WIDTH: load data, or `addr` for non-memory ops
- `out_rd` output 5, `out_reg_write` output 1
- `fault` output 1: pulses with `out_valid` on misaligned or illegal access

## Operation
- Accept on `in_valid && in_ready`. All inputs are latched on accept.
- Classification on accept:
  - Fault: any of the following.
    - `mem_read && mem_write`.
    - Load `funct3` ∈ {011, 110, 111}.
    - Store `funct3` ∉ {000, 001, 010}.
    - H/HU with `addr[0]`.
    - W with `addr[1:0] != 0`.
  - Non-memory: neither read nor write.
  - Otherwise load or store.
- FSM states:
  - IDLE
    - Fault → DONE with `fault=1` and `out_reg_write=0`.
    - Non-memory → DONE with `out_data=addr`.
    - Load/store → REQ.
  - REQ: `dmem_req_valid=1`. Request fields stay stable until `dmem_req_ready`. On handshake:
    - store → DONE;
    - load → RESP.
  - RESP: wait for `dmem_rsp_valid`. Register the extracted data, then → DONE.
  - DONE: `out_valid=1` for exactly one cycle, then → IDLE.
- Store lanes:
  - B: `be = 4'b0001 << addr[1:0]`, `wdata = {4{sd[7:0]}}`.
  - H: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{sd[15:0]}}`.
  - W: `be = 4'b1111`.
- Loads:
  - `dmem_be` is the same lane mask, `dmem_wdata = 0`.
  - Data is `rdata >> (8*addr[1:0])`.
  - B/H are sign-extended; BU/HU are zero-extended.
- `out_reg_write = reg_write && !fault`. Store results: `out_data = addr`.
- `dmem_rsp_valid` is ignored outside RESP.

## Timing
- Reset (async, any state): state=IDLE. All outputs are 0 except `in_ready=1`. An in-flight request is abandoned, and a late response is ignored.
- All outputs except `in_ready` are registered. `in_ready` is combinational from state.
- Accept at edge 0. Then:
  - Non-memory or fault: `out_valid` in cycle 1.
  - Store: `dmem_req_valid` from cycle 1. If `dmem_req_ready` in cycle n, then `out_valid` in cycle n+1.
  - Load: the response is sampled no earlier than the cycle after the handshake. If `rsp_valid` in cycle k, then `out_valid` in cycle k+1.
- Throughput:
  - A new op is accepted in the cycle after DONE at the earliest.
  - Non-memory: one op per 2 cycles.
  - Zero-wait store: one op per 3 cycles.
- `dmem_req_valid` never drops before `dmem_req_ready`.
- `dmem_addr`, `dmem_be`, `dmem_wdata` and `dmem_we` are constant throughout REQ.

## Test plan
- Non-memory op with `addr=0x1234_5678`, `rd=5`, `reg_write=1` → `out_valid` in cycle 1 with `out_data=0x1234_5678`, `out_rd=5`, `out_reg_write=1`, no dmem request.
- SB: `addr=0x103`, `store_data=0xAABBCCDD`, ready held low 3 cycles → request stable with `be=1000` and `wdata=0xDDDDDDDD` for all 4 cycles; `out_valid` the cycle after the handshake.
- LB and LBU: `addr=0x102`, `rdata=0x0080_0000` → `out_data=0xFFFF_FF80` and `0x0000_0080` respectively. LH: `addr=0x2`, `rdata=0x8001_0000` → `0xFFFF_8001`.
- LW at `addr=0x6` → no request; `out_valid` in cycle 1 with `fault=1`, `out_reg_write=0`. Same for `mem_read=mem_write=1`.
- LW, response delayed 5 cycles, with a spurious `rsp_valid` in IDLE beforehand → only the in-RESP response is used; `in_ready=0` throughout.
- Assert `rst_n` low in RESP, then a response arrives after release → all outputs 0, no `out_valid`, next op accepted normally.
